// File: rtl/alu_arbiter_if.sv
// Two-requester ALU request/grant/result bundle shared by the arbiter and its clients.
// Requesters drive the master side; the arbiter sits on the slave side.
interface alu_arbiter_if;
   logic        req0;
   logic [31:0] a0;
   logic [31:0] b0;
   logic [2:0]  sel0;
   logic        req1;
   logic [31:0] a1;
   logic [31:0] b1;
   logic [2:0]  sel1;
   logic        gnt0;
   logic        gnt1;
   logic        done0;
   logic        done1;
   logic [31:0] res;
   logic        zf;
   logic        err;
   logic        busy;

   modport slave (
      input  req0, a0, b0, sel0, req1, a1, b1, sel1,
      output gnt0, gnt1, done0, done1, res, zf, err, busy
   );

   modport master (
      output req0, a0, b0, sel0, req1, a1, b1, sel1,
      input  gnt0, gnt1, done0, done1, res, zf, err, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: gnt one cycle after the
// request is sampled, done one cycle later; requests wait (held high) while EXEC is busy.
module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  sel,
   output logic [31:0] res,
   output logic        zf
);
   always_comb begin
      res = '0;
      case (sel)
         3'b000:  res = a + b;
         3'b001:  res = a - b;
         3'b010:  res = a | b;
         3'b011:  res = a & b;
         3'b100:  res = {31'b0, (a < b)};
         default: res = '0;
      endcase
   end

   assign zf = (res == '0);
endmodule

module alu_arbiter (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] op_a, op_a_nxt;
   logic [31:0] op_b, op_b_nxt;
   logic [2:0]  op_sel, op_sel_nxt;
   logic        owner, owner_nxt;
   logic        last_owner, last_owner_nxt;
   logic        gnt0_q, gnt0_nxt, gnt1_q, gnt1_nxt;
   logic        done0_q, done0_nxt, done1_q, done1_nxt;
   logic [31:0] res_q, res_nxt;
   logic        zf_q, zf_nxt, err_q, err_nxt;

   logic        win;
   logic        illegal;
   logic [2:0]  alu_sel;
   logic [31:0] alu_res;
   logic        alu_zf;

   // Both requesting: favour whoever did not win last; otherwise the lone requester.
   assign win     = (bus.req0 && bus.req1) ? ~last_owner : bus.req1;
   assign illegal = (op_sel > 3'd4);
   // Illegal codes never reach the ALU; it sees a harmless add instead.
   assign alu_sel = illegal ? 3'd0 : op_sel;

   alu u_alu (
      .a   (op_a),
      .b   (op_b),
      .sel (alu_sel),
      .res (alu_res),
      .zf  (alu_zf)
   );

   always_comb begin
      state_nxt      = state;
      op_a_nxt       = op_a;
      op_b_nxt       = op_b;
      op_sel_nxt     = op_sel;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      gnt0_nxt       = 1'b0;
      gnt1_nxt       = 1'b0;
      done0_nxt      = 1'b0;
      done1_nxt      = 1'b0;
      res_nxt        = res_q;
      zf_nxt         = zf_q;
      err_nxt        = err_q;
      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_nxt      = EXEC;
               op_a_nxt       = win ? bus.a1 : bus.a0;
               op_b_nxt       = win ? bus.b1 : bus.b0;
               op_sel_nxt     = win ? bus.sel1 : bus.sel0;
               owner_nxt      = win;
               last_owner_nxt = win;
               gnt0_nxt       = ~win;
               gnt1_nxt       = win;
            end
         end
         EXEC: begin
            state_nxt = IDLE;
            done0_nxt = ~owner;
            done1_nxt = owner;
            if (illegal) begin
               res_nxt = '0;
               zf_nxt  = 1'b1;
               err_nxt = 1'b1;
            end else begin
               res_nxt = alu_res;
               zf_nxt  = alu_zf;
               err_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         op_sel     <= '0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         res_q      <= '0;
         zf_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         op_a       <= op_a_nxt;
         op_b       <= op_b_nxt;
         op_sel     <= op_sel_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         gnt0_q     <= gnt0_nxt;
         gnt1_q     <= gnt1_nxt;
         done0_q    <= done0_nxt;
         done1_q    <= done1_nxt;
         res_q      <= res_nxt;
         zf_q       <= zf_nxt;
         err_q      <= err_nxt;
      end
   end

   assign bus.gnt0  = gnt0_q;
   assign bus.gnt1  = gnt1_q;
   assign bus.done0 = done0_q;
   assign bus.done1 = done1_q;
   assign bus.res   = res_q;
   assign bus.zf    = zf_q;
   assign bus.err   = err_q;
   assign bus.busy  = (state == EXEC);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level scheduling model checked every cycle,
// directed scenarios pinned with literal results, then a randomized phase.
`timescale 1ns/1ps
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_arbiter_if bus ();
   alu_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // requester side: one outstanding op each, held until granted
   bit          pend [2];
   logic [31:0] qa [2];
   logic [31:0] qb [2];
   logic [2:0]  qs [2];
   bit          rand_en = 0;
   bit          hold_en = 0;

   // model: cycle numbers at which grant/done are due, plus visible result
   int          free_at, gnt_cyc, done_cyc, gnt_who, last;
   logic [31:0] p_res, m_res;
   bit          p_zf, p_err, m_zf, m_err;

   int          gnt_log [$];
   int          done_who [$];
   int          done_at [$];
   logic [31:0] done_res [$];
   bit          done_zf [$];
   bit          done_err [$];

   function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 3))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic [2:0] s);
      qa[i] = a; qb[i] = b; qs[i] = s; pend[i] = 1;
   endtask

   task automatic drive();
      bus.req0 = pend[0]; bus.a0 = qa[0]; bus.b0 = qb[0]; bus.sel0 = qs[0];
      bus.req1 = pend[1]; bus.a1 = qa[1]; bus.b1 = qb[1]; bus.sel1 = qs[1];
   endtask

   task automatic model_reset();
      free_at = 0; gnt_cyc = -1; done_cyc = -1; gnt_who = 0; last = 1;
      m_res = '0; m_zf = 0; m_err = 0;
      pend[0] = 0; pend[1] = 0;
      drive();
   endtask

   // Edge e samples the requests: grant visible in cycle e, result in e+1, next sample e+2.
   task automatic predict(int e);
      int w;
      logic [31:0] a, b;
      if (e >= free_at && (pend[0] || pend[1])) begin
         if (pend[0] && pend[1]) w = 1 - last;
         else                    w = pend[0] ? 0 : 1;
         last = w; gnt_cyc = e; gnt_who = w; done_cyc = e + 1; free_at = e + 2;
         a = qa[w]; b = qb[w]; p_err = 0;
         case (qs[w])
            3'd0:    p_res = a + b;
            3'd1:    p_res = a - b;
            3'd2:    p_res = a | b;
            3'd3:    p_res = a & b;
            3'd4:    p_res = (a < b) ? 32'd1 : 32'd0;
            default: begin p_res = 32'd0; p_err = 1; end
         endcase
         p_zf = (p_res == 32'd0);
      end
   endtask

   task automatic compare();
      bit g0, g1, d0, d1, by;
      if (cyc == done_cyc) begin m_res = p_res; m_zf = p_zf; m_err = p_err; end
      by = (cyc == gnt_cyc);
      g0 = by && gnt_who == 0;
      g1 = by && gnt_who == 1;
      d0 = (cyc == done_cyc) && gnt_who == 0;
      d1 = (cyc == done_cyc) && gnt_who == 1;
      check("outputs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.zf, bus.err, bus.res},
                       {g0, g1, d0, d1, by, m_zf, m_err, m_res});
      if (bus.gnt0) gnt_log.push_back(0);
      if (bus.gnt1) gnt_log.push_back(1);
      if (bus.done0 || bus.done1) begin
         done_who.push_back(bus.done1 ? 1 : 0);
         done_at.push_back(cyc);
         done_res.push_back(bus.res);
         done_zf.push_back(bus.zf);
         done_err.push_back(bus.err);
      end
   endtask

   task automatic plan();
      if (bus.gnt0) pend[0] = 0;
      if (bus.gnt1) pend[1] = 0;
      for (int i = 0; i < 2; i++)
         if (!pend[i] && (hold_en || (rand_en && $urandom_range(0, 2) != 0)))
            set_op(i, pick(), pick(), 3'($urandom_range(0, 7)));
      drive();
      if (rst_n) predict(cyc + 1);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      compare();
   endtask

   task automatic step();
      tick();
      plan();
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      repeat (2) tick();
      rst_n = 1;
      plan();
   endtask

   task automatic check_done(string name, int idx, int who, logic [31:0] r, bit z, bit e);
      if (idx >= done_who.size()) begin
         check({name, "_missing"}, 64'(done_who.size()), 64'(idx + 1));
      end else begin
         check(name, {8'(done_who[idx]), done_res[idx], 7'b0, done_zf[idx], 7'b0, done_err[idx]},
                     {8'(who), r, 7'b0, z, 7'b0, e});
      end
   endtask

   initial begin
      int n, k;
      rst_n = 0;
      qa[0] = '0; qb[0] = '0; qs[0] = '0; qa[1] = '0; qb[1] = '0; qs[1] = '0;
      model_reset();
      repeat (3) tick();
      check("reset_state", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.zf, bus.err, bus.res}, 64'd0);
      rst_n = 1;
      plan();

      // single add: 5 + 3
      n = done_who.size();
      set_op(0, 32'd5, 32'd3, 3'd0);
      repeat (4) step();
      check_done("add_5_3", n, 0, 32'd8, 0, 0);
      check("model_add", 64'(m_res), 64'd8);
      if (n < done_at.size() && gnt_log.size() > 0) begin end
      k = 0;

      // simultaneous after reset: requester 0 first, then 1 (wrap to zero)
      do_reset();
      n = done_who.size();
      k = gnt_log.size();
      set_op(0, 32'd7, 32'd7, 3'd1);
      set_op(1, 32'hFFFF_FFFF, 32'd1, 3'd0);
      repeat (6) step();
      check_done("both_first", n, 0, 32'd0, 1, 0);
      check_done("both_second", n + 1, 1, 32'd0, 1, 0);
      check("both_gnt_order", 64'(gnt_log.size() - k), 64'd2);
      if (gnt_log.size() >= k + 2) check("both_gnt_pattern", {32'(gnt_log[k]), 32'(gnt_log[k+1])}, {32'd0, 32'd1});

      // unsigned compare and an illegal op code
      n = done_who.size();
      set_op(1, 32'd2, 32'hFFFF_FFFF, 3'd4);
      repeat (4) step();
      check_done("sltu", n, 1, 32'd1, 0, 0);
      set_op(1, 32'd5, 32'd6, 3'd6);
      repeat (4) step();
      check_done("illegal", n + 1, 1, 32'd0, 1, 1);

      // both held continuously: alternating grants, a done every 2 cycles
      n = done_who.size();
      hold_en = 1;
      k = 0;
      while (done_who.size() < n + 8 && k < 60) begin step(); k++; end
      hold_en = 0;
      check("hold_done_count", 64'(done_who.size() - n), 64'd8);
      for (int i = 0; i < 8 && n + i < done_who.size(); i++) begin
         check("hold_owner", 64'(done_who[n+i]), 64'(i % 2));
         if (i > 0) check("hold_spacing", 64'(done_at[n+i] - done_at[n+i-1]), 64'd2);
      end
      repeat (10) step();

      // reset during EXEC aborts the op
      set_op(0, 32'd9, 32'd4, 3'd1);
      k = 0;
      while (!bus.busy && k < 10) begin step(); k++; end
      check("exec_reached", 64'(bus.busy), 64'd1);
      n = done_who.size();
      #2 rst_n = 0;
      model_reset();
      #1 check("async_reset", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.zf, bus.err, bus.res}, 64'd0);
      repeat (2) tick();
      rst_n = 1;
      plan();
      check("no_done_after_abort", 64'(done_who.size()), 64'(n));
      set_op(0, 32'd1, 32'd2, 3'd2);
      set_op(1, 32'd12, 32'd10, 3'd3);
      repeat (6) step();
      check_done("post_reset_first", n, 0, 32'd3, 0, 0);
      check_done("post_reset_second", n + 1, 1, 32'd8, 0, 0);

      // randomized traffic
      rand_en = 1;
      repeat (400) step();
      rand_en = 0;
      repeat (10) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: The block SHALL have exactly one clock, clk (input, 1, rising-edge); all state SHALL be updated on this edge only.
REQ-002: The block SHALL have reset rst_n (input, 1), asynchronous and active-low; the block SHALL enter reset immediately when rst_n is low, independent of clk.
REQ-003: req0 input 1 -- requester 0 operation request, held until gnt0.
REQ-004: a0, b0 input 32 each; sel0 input 3 -- requester 0 operands and ALU op code, stable while req0 is high.
REQ-005: req1, a1, b1, sel1 -- requester 1, same widths and rules as requester 0.
REQ-006: gnt0, gnt1 output 1 -- one-cycle pulse: operands of that requester were captured.
REQ-007: done0, done1 output 1 -- one-cycle pulse: res/zf/err hold that requester's result.
REQ-008: res output 32; zf output 1 -- registered result and zero flag of the last completed operation.
REQ-009: err output 1 -- the last completed operation had an illegal op code.
REQ-010: busy output 1 -- high while the state is EXEC.

Function
REQ-011: The block SHALL instantiate the team ALU (ops 000 add, 001 sub, 010 or, 011 and, 100 unsigned a<b as 32-bit 0/1), with its inputs driven only from internal operand registers.
REQ-012: The states SHALL be IDLE and EXEC.
REQ-013: In IDLE, on an edge where req0 or req1 is high: capture the winner's a, b, sel into operand registers; record owner; set gnt_owner=1 for the next cycle; go to EXEC.
REQ-014: In IDLE with no request: stay in IDLE; gnt and done SHALL be 0.
REQ-015: Arbitration SHALL be round-robin: with both requests high, grant the requester other than last_owner; with one request high, grant it regardless of last_owner.
REQ-016: last_owner SHALL update on every grant.
REQ-017: In EXEC, on the next edge: res<=ALU res, zf<=ALU ZF, err<=0, done_owner=1 for the following cycle, state<=IDLE.
REQ-018: Illegal sel (101, 110, 111) SHALL NOT be passed to the ALU; in EXEC the block SHALL instead load res=0, zf=1, err=1 and still pulse done_owner.
REQ-019: Latency SHALL be: gnt one cycle after the request is sampled, done one cycle after gnt; throughput is one operation per 2 cycles.
REQ-020: Requests SHALL be ignored in EXEC; a request held high through the done cycle SHALL be sampled at the end of that cycle as a new request (back-to-back allowed).
REQ-021: gnt0/gnt1 and done0/done1 SHALL never both be high in the same cycle.
REQ-022: res, zf and err SHALL hold their value between done pulses.
REQ-023: Arithmetic SHALL be 32-bit modulo (add/sub wrap, no carry or overflow output).

Reset
REQ-024: While rst_n=0: state=IDLE, gnt0=gnt1=0, done0=done1=0, res=0, zf=0, err=0, busy=0, last_owner=1 (requester 0 wins the first simultaneous request), operand registers=0.
REQ-025: Reset asserted in EXEC SHALL abort the operation with no done pulse.
REQ-026: After rst_n deasserts, the first request SHALL be sampled on the first rising edge with rst_n high.

Verification
REQ-027: req0 only, a0=5, b0=3, sel0=000 -> gnt0 at cycle+1, done0 at cycle+2, res=8, zf=0, err=0.
REQ-028: req0 and req1 together after reset, a0=7, b0=7, sel0=001; a1=0xFFFFFFFF, b1=1, sel1=000 -> requester 0 served first (res=0, zf=1), then requester 1 (res=0, zf=1, wrap); grants alternate.
REQ-029: Both requests held continuously for 8 ops -> gnt pattern 0,1,0,1... with done every 2 cycles and no lost or duplicate done.
REQ-030: req1 with sel1=100, a1=2, b1=0xFFFFFFFF -> res=1 (unsigned); with sel1=110 -> done1, res=0, zf=1, err=1.
REQ-031: rst_n low during EXEC -> no done pulse, all outputs 0 asynchronously; a request after release is served normally with requester 0 priority.
